mux41_rr_arbiter: RTL

- Round-robin arbiter sharing one 4:1 bit multiplexer (inputs i0..i3, selects s0/s1) among four requesters.
- Each requester i drives mux input i. The arbiter grants one requester at a time and drives s0/s1 so the mux output y carries the granted requester's input.
- Registered, single-clock controller that sits directly in front of the mux select pins.

---
 rtl/mux41_rr_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mux41_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux41_rr_arbiter
// Description : Round-robin arbiter that owns the select pins of a shared
//               4:1 bit multiplexer. Requester i drives mux input i. The
//               granted requester's index is driven onto {s1,s0}, so the mux
//               output carries that requester's data.
//
//   Ports
//     clk    in   1  system clock, rising edge
//     rst_n  in   1  asynchronous active-low reset
//     req    in   4  request vector, bit i = requester i
//     gnt    out  4  one-hot grant, registered, zero when idle
//     s0     out  1  mux select LSB, registered
//     s1     out  1  mux select MSB, registered
//     busy   out  1  high while any gnt bit is high
//
//   Optional feature
//     ARB_HOLD_EN : when defined, an owner keeps the grant while its request
//                   stays high, for at most MAX_HOLD consecutive cycles.
//                   When undefined, every grant lasts exactly one cycle.
//
// Revision    : 1.0  initial release
// ============================================================================
module mux41_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_GRANT = 1'b1;

    // The hold counter is 4 bits wide, so MAX_HOLD must fit 1..15.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_max_hold_range
        $error("mux41_rr_arbiter: MAX_HOLD must be in 1..15");
    end

    logic [0:0] r_state;
    logic [1:0] r_ptr;
    logic [1:0] r_sel;
    logic [3:0] r_gnt;

    logic [3:0] w_scan_req;
    logic [1:0] w_scan_ptr;
    logic [2:0] w_pick;
    logic       w_win_valid;
    logic [1:0] w_win_idx;
    logic       w_release;

    // Returns {found, index} of the first set bit scanning start, start+1,
    // start+2, start+3 (mod 4). Scanning from the far end lets the nearest
    // candidate overwrite the result last.
    function automatic logic [2:0] f_pick(input logic [3:0] reqs,
                                          input logic [1:0] start);
        logic [1:0] idx;
        f_pick = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (reqs[idx]) begin
                f_pick = {1'b1, idx};
            end
        end
    endfunction

`ifdef ARB_HOLD_EN
    localparam logic [3:0] c_HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [3:0] r_hold_cnt;

    // Release on request drop or when the owner has used its full window.
    assign w_release = !req[r_sel] || (r_hold_cnt == c_HOLD_LAST);
`else
    // Without holding, every grant is a single cycle.
    assign w_release = 1'b1;
`endif

    // In IDLE the scan starts at the stored pointer. While granted, the scan
    // models the post-release situation: the pointer has moved past the
    // owner and the owner's own request is masked, which forces rotation.
    always_comb begin
        w_scan_req = req;
        w_scan_ptr = r_ptr;
        if (r_state == c_ST_GRANT) begin
            w_scan_req = req & ~(4'b0001 << r_sel);
            w_scan_ptr = r_sel + 2'd1;
        end
    end

    assign w_pick      = f_pick(w_scan_req, w_scan_ptr);
    assign w_win_valid = w_pick[2];
    assign w_win_idx   = w_pick[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state <= c_ST_GRANT;
                        r_sel   <= w_win_idx;
                        r_gnt   <= 4'b0001 << w_win_idx;
                    end
                end
                c_ST_GRANT: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 2'd1;
                        if (w_win_valid) begin
                            // Back-to-back handover, no idle cycle.
                            r_sel <= w_win_idx;
                            r_gnt <= 4'b0001 << w_win_idx;
                        end else begin
                            // Select lines keep the last owner's index.
                            r_state <= c_ST_IDLE;
                            r_gnt   <= 4'b0000;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_gnt   <= 4'b0000;
                end
            endcase
        end
    end

`ifdef ARB_HOLD_EN
    // Counts cycles the current owner has held the grant; restarts on every
    // newly issued grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= 4'd0;
        end else if (r_state == c_ST_IDLE || w_release) begin
            r_hold_cnt <= 4'd0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end
`endif

    assign gnt  = r_gnt;
    assign s0   = r_sel[0];
    assign s1   = r_sel[1];
    assign busy = |r_gnt;

endmodule
`default_nettype wire
